// File: rtl/lsu_obi_initiator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lsu_obi_initiator: LSU data-port initiator (req/gnt/rvalid) with in-order |
// | load extraction. Optional checks: define LSU_OBI_INIT_ASSERT_EN.          |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module lsu_obi_initiator #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [1:0]  cmd_size_i,
    input  logic        cmd_unsigned_i,
    input  logic [31:0] cmd_addr_i,
    input  logic [31:0] cmd_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_we_o,
    output logic        resp_err_o,
    output logic        proto_err_o,
    output logic        data_req_o,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i
);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    typedef struct packed {
        logic [1:0] offset;
        logic [1:0] size;
        logic       is_unsigned;
        logic       we;
    } entry_t;

    state_t           state, state_next;
    entry_t           fifo [MAX_OUTSTANDING];
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] pend_cnt, gnt_cnt;

    logic        misaligned, accept_aligned, accept_misaligned;
    logic        handshake, pop, spurious;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc, shifted, load_data;

    always_comb begin
        misaligned = (cmd_size_i == 2'd3)
                  || (cmd_size_i == 2'd2 && cmd_addr_i[1:0] != 2'b00)
                  || (cmd_size_i == 2'd1 && cmd_addr_i[0]);
    end

    // Misaligned commands only go through an empty pipe so their error response cannot overtake bus responses
    assign cmd_ready_o = !rst && (misaligned
                       ? (state == IDLE && pend_cnt == '0)
                       : ((state == IDLE || data_gnt_i) && pend_cnt < MAX_CNT));

    assign accept_aligned    = cmd_valid_i && cmd_ready_o && !misaligned;
    assign accept_misaligned = cmd_valid_i && cmd_ready_o && misaligned;
    assign data_req_o        = (state == REQ);
    assign handshake         = data_req_o && data_gnt_i;
    assign pop               = data_rvalid_i && (gnt_cnt != '0);
    assign spurious          = data_rvalid_i && (gnt_cnt == '0);
    assign head              = fifo[rd_ptr];

    always_comb begin
        be_calc    = 4'hF;
        wdata_calc = cmd_wdata_i;
        case (cmd_size_i)
            2'd0: begin
                be_calc    = 4'b0001 << cmd_addr_i[1:0];
                wdata_calc = {4{cmd_wdata_i[7:0]}};
            end
            2'd1: begin
                be_calc    = 4'b0011 << cmd_addr_i[1:0];
                wdata_calc = {2{cmd_wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        shifted   = data_rdata_i >> {head.offset, 3'b000};
        load_data = data_rdata_i;
        case (head.size)
            2'd0: load_data = {{24{shifted[7]  & ~head.is_unsigned}}, shifted[7:0]};
            2'd1: load_data = {{16{shifted[15] & ~head.is_unsigned}}, shifted[15:0]};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // A grant coinciding with a new accept keeps REQ asserted with the new request
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept_aligned) state_next = REQ;
            REQ:     if (data_gnt_i && !accept_aligned) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_addr_o  <= '0;
            data_we_o    <= 1'b0;
            data_be_o    <= '0;
            data_wdata_o <= '0;
        end else if (accept_aligned) begin
            data_addr_o  <= {cmd_addr_i[31:2], 2'b00};
            data_we_o    <= cmd_we_i;
            data_be_o    <= be_calc;
            data_wdata_o <= wdata_calc;
        end
    end

    always_ff @(posedge clk) begin
        if (accept_aligned) begin
            fifo[wr_ptr] <= '{offset: cmd_addr_i[1:0], size: cmd_size_i,
                              is_unsigned: cmd_unsigned_i, we: cmd_we_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            pend_cnt <= '0;
            gnt_cnt  <= '0;
        end else begin
            if (accept_aligned) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)            rd_ptr <= rd_ptr + PTR_W'(1);
            case ({accept_aligned, pop})
                2'b10:   pend_cnt <= pend_cnt + ONE;
                2'b01:   pend_cnt <= pend_cnt - ONE;
                default: ;
            endcase
            case ({handshake, pop})
                2'b10:   gnt_cnt <= gnt_cnt + ONE;
                2'b01:   gnt_cnt <= gnt_cnt - ONE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_o <= 1'b0;
            resp_rdata_o <= '0;
            resp_we_o    <= 1'b0;
            resp_err_o   <= 1'b0;
            proto_err_o  <= 1'b0;
        end else begin
            resp_valid_o <= pop || accept_misaligned;
            resp_err_o   <= accept_misaligned;
            resp_we_o    <= pop ? head.we : (accept_misaligned && cmd_we_i);
            resp_rdata_o <= (pop && !head.we) ? load_data : '0;
            proto_err_o  <= proto_err_o | spurious;
        end
    end

`ifdef LSU_OBI_INIT_ASSERT_EN
    a_spurious: assert property (@(posedge clk) disable iff (rst) !spurious)
        else $error("rvalid with no granted transaction outstanding");
    a_stable: assert property (@(posedge clk) disable iff (rst)
        (data_req_o && !data_gnt_i) |=> (data_req_o && $stable(data_addr_o) && $stable(data_we_o)
                                         && $stable(data_be_o) && $stable(data_wdata_o)))
        else $error("request changed before grant");
    a_pend: assert property (@(posedge clk) disable iff (rst) pend_cnt <= MAX_CNT)
        else $error("pend_cnt overflow");
`endif

endmodule
`default_nettype wire

// File: tb/tb_lsu_obi_initiator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_lsu_obi_initiator: directed bench with a transaction-level model.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_lsu_obi_initiator;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid_i = 1'b0, cmd_we_i = 1'b0, cmd_unsigned_i = 1'b0;
    logic [1:0]  cmd_size_i = 2'd2;
    logic [31:0] cmd_addr_i = '0, cmd_wdata_i = '0;
    logic        cmd_ready_o, resp_valid_o, resp_we_o, resp_err_o, proto_err_o;
    logic [31:0] resp_rdata_o;
    logic        data_req_o, data_we_o;
    logic [31:0] data_addr_o, data_wdata_o;
    logic [3:0]  data_be_o;
    logic        data_gnt_i = 1'b0, data_rvalid_i = 1'b0;
    logic [31:0] data_rdata_i = '0;

    lsu_obi_initiator #(.MAX_OUTSTANDING(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_size_i(cmd_size_i), .cmd_unsigned_i(cmd_unsigned_i), .cmd_addr_i(cmd_addr_i),
        .cmd_wdata_i(cmd_wdata_i), .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o),
        .resp_we_o(resp_we_o), .resp_err_o(resp_err_o), .proto_err_o(proto_err_o),
        .data_req_o(data_req_o), .data_addr_o(data_addr_o), .data_we_o(data_we_o),
        .data_be_o(data_be_o), .data_wdata_o(data_wdata_o), .data_gnt_i(data_gnt_i),
        .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;
    typedef struct packed {
        logic [31:0] rdata;
        logic        we;
        logic        err;
    } rsp_t;

    int          vectors = 0;
    int          errors  = 0;
    bus_t        exp_bus[$];
    rsp_t        exp_rsp[$];
    logic [31:0] ref_mem [1024];
    logic [31:0] bfm_mem [1024];
    logic [31:0] bfm_rdq[$];
    int          gnt_wait = 0;
    bit          hold_rsp = 0;
    bit          spurious = 0;
    logic [31:0] last_rdata = '0, last_wdata = '0;
    logic [3:0]  last_be = '0;
    logic        last_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'(a[11:2]);
    endfunction

    // Load result from plain arithmetic: shift, truncate, then sign-extend by offsetting.
    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] size,
                                               input logic uns, input int off);
        longint unsigned v, span;
        if (size == 2'd2) return w;
        v    = w;
        v    = v >> (8 * off);
        span = (size == 2'd0) ? 64'd256 : 64'd65536;
        v    = v % span;
        if (!uns && v >= span / 2) v = v + 64'h1_0000_0000 - span;
        return v[31:0];
    endfunction

    task automatic model_accept(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wd);
        bus_t b;
        rsp_t r;
        int   off;
        off = int'(addr % 4);
        if (size == 2'd3 || (size == 2'd1 && off % 2 != 0) || (size == 2'd2 && off != 0)) begin
            r = '{rdata: 32'h0, we: we, err: 1'b1};
            exp_rsp.push_back(r);
            return;
        end
        b.addr  = addr - off;
        b.we    = we;
        b.be    = (size == 2'd2) ? 4'hF : 4'((size == 2'd0 ? 1 : 3) << off);
        b.wdata = (size == 2'd0) ? wd[7:0] * 32'h0101_0101
                : (size == 2'd1) ? wd[15:0] * 32'h0001_0001 : wd;
        exp_bus.push_back(b);
        if (we) begin
            for (int i = 0; i < 4; i++)
                if (b.be[i]) ref_mem[widx(addr)][8*i +: 8] = b.wdata[8*i +: 8];
            r = '{rdata: 32'h0, we: 1'b1, err: 1'b0};
        end else begin
            r = '{rdata: model_load(ref_mem[widx(addr)], size, uns, off), we: 1'b0, err: 1'b0};
        end
        exp_rsp.push_back(r);
    endtask

    // Responder plus per-cycle compare, all at the falling edge.
    initial begin : bfm
        bus_t held;
        rsp_t e;
        bit   req_prev, gnt_prev, rv_prev;
        int   waitc;
        req_prev = 0; gnt_prev = 0; rv_prev = 0; waitc = 0; held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
                bfm_rdq.delete();
                req_prev = 0; gnt_prev = 0; rv_prev = 0; waitc = 0;
                continue;
            end
            if (rv_prev && bfm_rdq.size() > 0) void'(bfm_rdq.pop_front());
            if (req_prev && gnt_prev) begin
                if (held.we) begin
                    for (int i = 0; i < 4; i++)
                        if (held.be[i]) bfm_mem[widx(held.addr)][8*i +: 8] = held.wdata[8*i +: 8];
                    bfm_rdq.push_back(32'h0);
                end else begin
                    bfm_rdq.push_back(bfm_mem[widx(held.addr)]);
                end
            end
            if (resp_valid_o) begin
                if (exp_rsp.size() == 0) begin
                    check("unexpected_resp_valid", 32'(resp_valid_o), 32'h0);
                end else begin
                    e = exp_rsp.pop_front();
                    check("resp_rdata", resp_rdata_o, e.rdata);
                    check("resp_we", 32'(resp_we_o), 32'(e.we));
                    check("resp_err", 32'(resp_err_o), 32'(e.err));
                    last_rdata = resp_rdata_o;
                    last_err   = resp_err_o;
                end
            end
            gnt_prev = 0;
            data_gnt_i = 1'b0;
            if (data_req_o) begin
                if (exp_bus.size() == 0) begin
                    check("unexpected_data_req", 32'(data_req_o), 32'h0);
                end else begin
                    check("bus_addr", data_addr_o, exp_bus[0].addr);
                    check("bus_we", 32'(data_we_o), 32'(exp_bus[0].we));
                    check("bus_be", 32'(data_be_o), 32'(exp_bus[0].be));
                    check("bus_wdata", data_wdata_o, exp_bus[0].wdata);
                    held = '{addr: data_addr_o, we: data_we_o, be: data_be_o, wdata: data_wdata_o};
                    if (waitc >= gnt_wait) begin
                        data_gnt_i = 1'b1; gnt_prev = 1; waitc = 0;
                        void'(exp_bus.pop_front());
                        last_be    = data_be_o;
                        last_wdata = data_wdata_o;
                    end else begin
                        waitc++;
                    end
                end
            end
            req_prev = data_req_o;
            rv_prev  = 0;
            if (spurious) begin
                data_rvalid_i = 1'b1; data_rdata_i = 32'h5A5A_5A5A; spurious = 0;
            end else if (!hold_rsp && bfm_rdq.size() > 0) begin
                data_rvalid_i = 1'b1; data_rdata_i = bfm_rdq[0]; rv_prev = 1;
            end else begin
                data_rvalid_i = 1'b0; data_rdata_i = 32'hDEAD_BEEF;
            end
        end
    end

    task automatic send(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd);
        int n = 0;
        @(negedge clk);
        cmd_valid_i = 1'b1; cmd_we_i = we; cmd_size_i = size; cmd_unsigned_i = uns;
        cmd_addr_i = addr; cmd_wdata_i = wd;
        #2;
        while (!cmd_ready_o) begin
            n++;
            if (n > 200) begin
                check("cmd_ready_timeout", 32'(cmd_ready_o), 32'h1);
                cmd_valid_i = 1'b0;
                return;
            end
            @(negedge clk); #2;
        end
        model_accept(we, size, uns, addr, wd);
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_rsp.size() != 0 || exp_bus.size() != 0) && n < 200) begin
            @(negedge clk); n++;
        end
        if (n >= 200) check("drain_timeout", 32'(exp_rsp.size() + exp_bus.size()), 32'h0);
        @(negedge clk);
    endtask

    task automatic load_check(input logic [1:0] size, input logic uns, input logic [31:0] addr,
                              input logic [31:0] exp, input string name);
        send(1'b0, size, uns, addr, 32'h0);
        drain();
        check(name, last_rdata, exp);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        for (int i = 0; i < 1024; i++) begin
            ref_mem[i] = i * 32'h9E37_79B1;
            bfm_mem[i] = i * 32'h9E37_79B1;
        end
        repeat (3) @(negedge clk);
        check("rst_data_req", 32'(data_req_o), 32'h0);
        check("rst_resp_valid", 32'(resp_valid_o), 32'h0);
        check("rst_resp_rdata", resp_rdata_o, 32'h0);
        check("rst_proto_err", 32'(proto_err_o), 32'h0);
        check("rst_cmd_ready", 32'(cmd_ready_o), 32'h0);
        rst = 1'b0;

        // Spurious rvalid with nothing outstanding
        @(negedge clk); #3; spurious = 1;
        repeat (2) @(negedge clk);
        check("proto_err_set", 32'(proto_err_o), 32'h1);

        send(1'b1, 2'd2, 1'b0, 32'h2010, 32'h1234_5678);
        drain();
        check("sw_be", 32'(last_be), 32'hF);
        check("sw_wdata", last_wdata, 32'h1234_5678);
        load_check(2'd2, 1'b0, 32'h2010, 32'h1234_5678, "lw_rdata");

        send(1'b1, 2'd2, 1'b0, 32'h2010, 32'h80FF_7F01);
        drain();
        load_check(2'd0, 1'b0, 32'h2013, 32'hFFFF_FF80, "lb_2013");
        load_check(2'd0, 1'b1, 32'h2013, 32'h0000_0080, "lbu_2013");
        load_check(2'd1, 1'b0, 32'h2012, 32'hFFFF_80FF, "lh_2012");
        load_check(2'd0, 1'b0, 32'h2011, 32'h0000_007F, "lb_2011");
        load_check(2'd1, 1'b1, 32'h2010, 32'h0000_7F01, "lhu_2010");

        send(1'b1, 2'd0, 1'b0, 32'h2011, 32'hFFFF_FFAB);
        drain();
        check("sb_be", 32'(last_be), 32'h2);
        check("sb_wdata", last_wdata, 32'hABAB_ABAB);
        load_check(2'd2, 1'b0, 32'h2010, 32'h80FF_AB01, "lw_after_sb");

        // Stalled grants: request must hold steady while waiting
        gnt_wait = 2;
        send(1'b1, 2'd1, 1'b0, 32'h3002, 32'h0000_BEEF);
        send(1'b0, 2'd1, 1'b0, 32'h3002, 32'h0);
        send(1'b0, 2'd0, 1'b1, 32'h3003, 32'h0);
        drain();
        gnt_wait = 0;
        for (int i = 0; i < 4; i++) send(1'b0, 2'd0, 1'b0, 32'h3000 + i, 32'h0);
        drain();

        // Misaligned commands
        send(1'b0, 2'd2, 1'b0, 32'h2002, 32'h0);
        @(negedge clk);
        check("misal_no_req", 32'(data_req_o), 32'h0);
        drain();
        check("misal_err", 32'(last_err), 32'h1);
        check("misal_rdata", last_rdata, 32'h0);
        send(1'b1, 2'd1, 1'b0, 32'h2011, 32'h1234);
        send(1'b0, 2'd3, 1'b0, 32'h2010, 32'h0);
        drain();

        // Full queue: grants immediate, responses withheld
        hold_rsp = 1;
        for (int i = 0; i < 4; i++) send(1'b0, 2'd2, 1'b0, 32'h100 + 4 * i, 32'h0);
        cmd_addr_i = 32'h200; cmd_size_i = 2'd2;
        repeat (3) begin
            @(negedge clk); #2;
            check("full_not_ready", 32'(cmd_ready_o), 32'h0);
        end
        hold_rsp = 0;
        @(negedge clk); #2;
        check("full_rvalid_seen", 32'(data_rvalid_i), 32'h1);
        check("full_ready_with_rvalid", 32'(cmd_ready_o), 32'h0);
        send(1'b0, 2'd2, 1'b0, 32'h200, 32'h0);
        drain();
        check("proto_err_sticky", 32'(proto_err_o), 32'h1);

        // Reset mid-transaction, then a stray rvalid
        hold_rsp = 1;
        send(1'b0, 2'd2, 1'b0, 32'h140, 32'h0);
        @(negedge clk); #3;
        rst = 1'b1; hold_rsp = 0;
        exp_bus.delete(); exp_rsp.delete();
        repeat (2) @(negedge clk);
        #3; rst = 1'b0;
        @(negedge clk);
        check("proto_err_cleared", 32'(proto_err_o), 32'h0);
        #3; spurious = 1;
        repeat (2) @(negedge clk);
        check("proto_err_after_rst", 32'(proto_err_o), 32'h1);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
`default_nettype wire
